cpu: RTL and testbench

CPU -- requirements
Module: cpu

---
 rtl/cpu.sv | 149 ++++++++++++++
 tb/tb_cpu.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/cpu.sv
// 8-bit single-bus accumulator machine: 16x8 RAM, 4-bit PC/MAR, 5-step instruction cycle.
// RAM is reloaded with the default program whenever rst is high.
module cpu (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] bus,
  output logic [3:0] mem_address_data,
  output logic [7:0] mem_data,
  output logic [7:0] a_data,
  output logic [7:0] b_data,
  output logic [7:0] alu_data,
  output logic [7:0] instruction_data,
  output logic [7:0] display_data,
  output logic [3:0] pc_data,
  output logic       ovf,
  output logic       zf
);

  typedef enum logic [2:0] {T0, T1, T2, T3, T4} step_t;

  localparam logic [3:0] OP_LDA = 4'd1, OP_ADD = 4'd2, OP_SUB = 4'd3, OP_STA = 4'd4,
                         OP_LDI = 4'd5, OP_JMP = 4'd6, OP_JC  = 4'd7, OP_JZ  = 4'd8,
                         OP_OUT = 4'd14, OP_HLT = 4'd15;

  step_t      step_q, step_d;
  logic [3:0] pc_q, pc_d, mar_q, mar_d;
  logic [7:0] a_q, a_d, b_q, b_d, ir_q, ir_d, disp_q, disp_d;
  logic       ovf_q, ovf_d, zf_q, zf_d, halt_q, halt_d;
  logic [7:0] mem_q [16];

  logic pc_out, ram_out, io_out, a_out, alu_out;
  logic mar_ld, ir_ld, pc_inc, pc_jmp, a_ld, b_ld, ram_we, disp_ld, flags_ld, halt_set, sub;

  logic [3:0] opcode, operand;
  logic [8:0] alu_res;

  assign opcode  = ir_q[7:4];
  assign operand = ir_q[3:0];

  // Step sequencer and control decode; everything freezes once halted.
  always_comb begin
    step_d   = step_q;
    pc_out   = 1'b0; ram_out = 1'b0; io_out = 1'b0; a_out = 1'b0; alu_out = 1'b0;
    mar_ld   = 1'b0; ir_ld   = 1'b0; pc_inc = 1'b0; pc_jmp = 1'b0;
    a_ld     = 1'b0; b_ld    = 1'b0; ram_we = 1'b0; disp_ld = 1'b0;
    flags_ld = 1'b0; halt_set = 1'b0; sub   = 1'b0;
    if (!halt_q) begin
      step_d = (step_q == T4) ? T0 : step_t'(step_q + 3'd1);
      case (step_q)
        T0: begin pc_out = 1'b1; mar_ld = 1'b1; end
        T1: begin ram_out = 1'b1; ir_ld = 1'b1; pc_inc = 1'b1; end
        T2: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin io_out = 1'b1; mar_ld = 1'b1; end
            OP_LDI: begin io_out = 1'b1; a_ld = 1'b1; end
            OP_JMP: pc_jmp = 1'b1;
            OP_JC:  pc_jmp = ovf_q;
            OP_JZ:  pc_jmp = zf_q;
            OP_OUT: begin a_out = 1'b1; disp_ld = 1'b1; end
            OP_HLT: halt_set = 1'b1;
            default: ;
          endcase
        end
        T3: begin
          case (opcode)
            OP_LDA: begin ram_out = 1'b1; a_ld = 1'b1; end
            OP_ADD, OP_SUB: begin ram_out = 1'b1; b_ld = 1'b1; end
            OP_STA: begin a_out = 1'b1; ram_we = 1'b1; end
            default: ;
          endcase
        end
        T4: begin
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            alu_out  = 1'b1;
            a_ld     = 1'b1;
            flags_ld = 1'b1;
            sub      = (opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  // Subtract is A + ~B + 1, so carry=1 means no borrow.
  assign alu_res = {1'b0, a_q} + {1'b0, (sub ? ~b_q : b_q)} + {8'd0, sub};

  always_comb begin
    bus = 8'h00;
    if (pc_out)  bus = {4'h0, pc_q};
    if (ram_out) bus = mem_q[mar_q];
    if (io_out)  bus = {4'h0, operand};
    if (a_out)   bus = a_q;
    if (alu_out) bus = alu_res[7:0];
  end

  always_comb begin
    pc_d   = pc_jmp ? operand : (pc_inc ? pc_q + 4'd1 : pc_q);
    mar_d  = mar_ld  ? bus[3:0] : mar_q;
    a_d    = a_ld    ? bus : a_q;
    b_d    = b_ld    ? bus : b_q;
    ir_d   = ir_ld   ? bus : ir_q;
    disp_d = disp_ld ? bus : disp_q;
    ovf_d  = flags_ld ? alu_res[8] : ovf_q;
    zf_d   = flags_ld ? (alu_res[7:0] == 8'h00) : zf_q;
    halt_d = halt_q | halt_set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q <= T0;
      pc_q   <= '0;
      mar_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      ir_q   <= '0;
      disp_q <= '0;
      ovf_q  <= 1'b0;
      zf_q   <= 1'b0;
      halt_q <= 1'b0;
      mem_q  <= '{8'hE0, 8'h2F, 8'h74, 8'h60, 8'h3F, 8'hE0, 8'h80, 8'h64,
                 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
    end else begin
      step_q <= step_d;
      pc_q   <= pc_d;
      mar_q  <= mar_d;
      a_q    <= a_d;
      b_q    <= b_d;
      ir_q   <= ir_d;
      disp_q <= disp_d;
      ovf_q  <= ovf_d;
      zf_q   <= zf_d;
      halt_q <= halt_d;
      if (ram_we) mem_q[mar_q] <= bus;
    end
  end

  assign mem_address_data = mar_q;
  assign mem_data         = mem_q[mar_q];
  assign a_data           = a_q;
  assign b_data           = b_q;
  assign alu_data         = alu_res[7:0];
  assign instruction_data = ir_q;
  assign display_data     = disp_q;
  assign pc_data          = pc_q;
  assign ovf              = ovf_q;
  assign zf               = zf_q;

endmodule

// File: tb/tb_cpu.sv
// Directed bench for cpu: walks the default count-up/count-down program and checks
// state at hand-computed clock counts after reset release.
module tb_cpu;
  logic       clk, rst;
  logic [7:0] bus, mem_data, a_data, b_data, alu_data, instruction_data, display_data;
  logic [3:0] mem_address_data, pc_data;
  logic       ovf, zf;

  int total  = 0;
  int passed = 0;
  int e      = 0;

  cpu dut (
    .clk(clk), .rst(rst), .bus(bus), .mem_address_data(mem_address_data),
    .mem_data(mem_data), .a_data(a_data), .b_data(b_data), .alu_data(alu_data),
    .instruction_data(instruction_data), .display_data(display_data),
    .pc_data(pc_data), .ovf(ovf), .zf(zf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance to 'target' rising edges after reset release, then sample 1ns later.
  task automatic run_to(input int target);
    while (e < target) begin
      @(posedge clk);
      e++;
    end
    #1;
  endtask

  task automatic chk_reset_state(input string pfx);
    chk({pfx, "_a"},    a_data, 8'h00);
    chk({pfx, "_b"},    b_data, 8'h00);
    chk({pfx, "_pc"},   {4'h0, pc_data}, 8'h00);
    chk({pfx, "_mar"},  {4'h0, mem_address_data}, 8'h00);
    chk({pfx, "_ir"},   instruction_data, 8'h00);
    chk({pfx, "_disp"}, display_data, 8'h00);
    chk({pfx, "_flg"},  {6'd0, ovf, zf}, 8'h00);
    chk({pfx, "_bus"},  bus, 8'h00);
    chk({pfx, "_alu"},  alu_data, 8'h00);
    chk({pfx, "_mem"},  mem_data, 8'hE0);
  endtask

  initial begin
    rst = 1'b0;
    #1 rst = 1'b1;
    #2 chk_reset_state("rst");
    @(posedge clk);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    e = 0;

    // First OUT fetch
    run_to(3);
    chk("fetch_mar", {4'h0, mem_address_data}, 8'h00);
    chk("fetch_ir",  instruction_data, 8'hE0);
    chk("fetch_pc",  {4'h0, pc_data}, 8'h01);
    chk("fetch_disp", display_data, 8'h00);
    chk("idle_bus",  bus, 8'h00);
    // ADD 15 execute steps
    run_to(7);
    chk("add_t2_bus", bus, 8'h0F);
    chk("add_ir",     instruction_data, 8'h2F);
    run_to(8);
    chk("add_t3_mar", {4'h0, mem_address_data}, 8'h0F);
    chk("add_t3_bus", bus, 8'h01);
    chk("add_t3_mem", mem_data, 8'h01);
    run_to(9);
    chk("add_t4_b",   b_data, 8'h01);
    chk("add_t4_alu", alu_data, 8'h01);
    run_to(10);
    chk("add1_a", a_data, 8'h01);
    run_to(20);
    chk("loop1_a",   a_data, 8'h01);
    chk("loop1_flg", {6'd0, ovf, zf}, 8'h00);
    chk("loop1_pc",  {4'h0, pc_data}, 8'h00);
    run_to(23);
    chk("out1_disp", display_data, 8'h01);

    // Count-up wraps FF -> 00
    run_to(5100);
    chk("up_ff_a",    a_data, 8'hFF);
    chk("up_fe_disp", display_data, 8'hFE);
    run_to(5110);
    chk("wrap_a",   a_data, 8'h00);
    chk("wrap_flg", {6'd0, ovf, zf}, 8'h03);
    run_to(5115);
    chk("jc_pc", {4'h0, pc_data}, 8'h04);
    run_to(5118);
    chk("sub_t3_alu_add", alu_data, 8'h01);
    run_to(5119);
    chk("sub_t4_alu", alu_data, 8'hFF);
    run_to(5120);
    chk("sub_a",   a_data, 8'hFF);
    chk("sub_flg", {6'd0, ovf, zf}, 8'h00);
    run_to(5125);
    chk("down_disp", display_data, 8'hFF);
    run_to(5130);
    chk("jz_nt_pc", {4'h0, pc_data}, 8'h07);
    run_to(5135);
    chk("jmp4_pc", {4'h0, pc_data}, 8'h04);

    // Countdown reaches zero
    run_to(10200);
    chk("down_01_a", a_data, 8'h01);
    run_to(10220);
    chk("zero_a",   a_data, 8'h00);
    chk("zero_flg", {6'd0, ovf, zf}, 8'h03);
    run_to(10225);
    chk("zero_disp", display_data, 8'h00);
    run_to(10230);
    chk("jz_pc", {4'h0, pc_data}, 8'h00);
    run_to(10240);
    chk("resume_a",   a_data, 8'h01);
    chk("resume_flg", {6'd0, ovf, zf}, 8'h00);
    run_to(10245);
    chk("resume_jc_pc", {4'h0, pc_data}, 8'h03);

    // Reset during ADD T3
    run_to(10258);
    chk("pre_rst_bus", bus, 8'h01);
    chk("pre_rst_a",   a_data, 8'h01);
    #1 rst = 1'b1;
    #1 chk_reset_state("mid");
    @(negedge clk) rst = 1'b0;
    e = 0;
    run_to(3);
    chk("re_ir", instruction_data, 8'hE0);
    chk("re_pc", {4'h0, pc_data}, 8'h01);
    run_to(10);
    chk("re_add_a", a_data, 8'h01);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
